// File: rtl/uart_rx.sv
// UART receiver: START, 8 data bits LSB first, PARITY, STOP.
// Two-flop line synchroniser, mid-bit sampling, one-cycle valid strobe.
module uart_rx #(
    parameter int CLK_FREQ  = 60000000,
    parameter int BAUD_RATE = 6000000,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic        PAR_BIT = 1'(PARITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s;
    logic [15:0] clk_cnt, clk_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_reg, shift_n;
    logic        pbit, pbit_n;
    logic [7:0]  data_n;
    logic        valid_n, perr_n, ferr_n;
    logic        bit_pt;

    // Line idles high, so the synchroniser resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            pbit       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_n;
            pbit       <= pbit_n;
            rx_data    <= data_n;
            rx_valid   <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    assign bit_pt  = (clk_cnt == BIT_M1);
    assign rx_busy = (state != S_IDLE);

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        pbit_n    = pbit;
        data_n    = rx_data;
        perr_n    = parity_err;
        ferr_n    = frame_err;
        valid_n   = 1'b0;

        unique case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s)
                    state_n = S_START;
            end
            S_START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (clk_cnt == HALF_M1) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_pt) begin
                    clk_cnt_n        = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7)
                        state_n = S_PARITY;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end
            end
            S_PARITY: begin
                if (bit_pt) begin
                    clk_cnt_n = '0;
                    pbit_n    = rx_s;
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_pt) begin
                    clk_cnt_n = '0;
                    data_n    = shift_reg;
                    perr_n    = ((^shift_reg) ^ pbit) != PAR_BIT;
                    ferr_n    = ~rx_s;
                    valid_n   = 1'b1;
                    state_n   = rx_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // Break or stuck-low line: hold off until it returns high.
                clk_cnt_n = '0;
                if (rx_s)
                    state_n = S_IDLE;
            end
            default: begin
                clk_cnt_n = '0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: even-parity instance plus an odd-parity
// instance sharing the same line.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data0, rx_data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, busy0, busy1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int         n0 = 0;
    int         n1 = 0;
    int         cq0[$];
    logic [7:0] dq0[$];
    logic       eq0[$];
    logic       pe1_last;

    int start_cyc;
    int busy_low;
    int nb;
    int lat;

    uart_rx #(.PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data0), .rx_valid(v0),
        .parity_err(pe0), .frame_err(fe0), .rx_busy(busy0)
    );

    uart_rx #(.PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data1), .rx_valid(v1),
        .parity_err(pe1), .frame_err(fe1), .rx_busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) begin
            n0++;
            cq0.push_back(cyc);
            dq0.push_back(rx_data0);
            eq0.push_back(pe0 | fe0);
        end
        if (v1) begin
            n1++;
            pe1_last = pe1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one full frame; counts cycles where rx_busy is low mid-frame.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        logic [10:0] bits;
        int k;
        bits = {s, p, d, 1'b0};
        start_cyc = cyc;
        busy_low = 0;
        k = 0;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (CPB) begin
                @(posedge clk);
                #1;
                k++;
                if (k >= 4 && k <= 107 && !busy0)
                    busy_low++;
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rx = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rx_data0, 8'h00);
        chk("rst_valid", v0, 1'b0);
        chk("rst_perr", pe0, 1'b0);
        chk("rst_ferr", fe0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        reset = 1'b0;
        idle(5);

        // 0xA5, correct even parity
        nb = n0;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(5);
        chk("a5_count", n0 - nb, 1);
        lat = cq0[nb] - start_cyc;
        chk("a5_lat_window", (lat >= 103 && lat <= 110), 1'b1);
        chk("a5_data", rx_data0, 8'hA5);
        chk("a5_perr", pe0, 1'b0);
        chk("a5_ferr", fe0, 1'b0);
        chk("a5_busy_frame", busy_low, 0);
        chk("a5_odd_perr", pe1_last, 1'b1);

        // 0x07 wrong then right parity
        nb = n0;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(5);
        chk("07p0_count", n0 - nb, 1);
        chk("07p0_data", rx_data0, 8'h07);
        chk("07p0_perr", pe0, 1'b1);
        chk("07p0_ferr", fe0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        chk("07p1_perr", pe0, 1'b0);

        // 0x3C with low stop bit, line held low
        nb = n0;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("3c_count", n0 - nb, 1);
        chk("3c_data", rx_data0, 8'h3C);
        chk("3c_ferr", fe0, 1'b1);
        chk("3c_perr", pe0, 1'b0);
        chk("3c_busy_wait", busy0, 1'b1);
        idle(5);
        chk("3c_busy_release", busy0, 1'b0);
        idle(20);
        chk("3c_no_second", n0 - nb, 1);

        // Short glitch on the line
        nb = n0;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("glitch_busy", busy0, 1'b0);
        idle(120);
        chk("glitch_novalid", n0 - nb, 0);

        // Back-to-back frames
        nb = n0;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(5);
        chk("b2b_count", n0 - nb, 4);
        if (n0 - nb >= 4) begin
            chk("b2b_d0", dq0[nb], 8'h55);
            chk("b2b_d1", dq0[nb + 1], 8'hAA);
            chk("b2b_d2", dq0[nb + 2], 8'h00);
            chk("b2b_d3", dq0[nb + 3], 8'hFF);
            chk("b2b_gap1", cq0[nb + 1] - cq0[nb], 110);
            chk("b2b_gap2", cq0[nb + 2] - cq0[nb + 1], 110);
            chk("b2b_gap3", cq0[nb + 3] - cq0[nb + 2], 110);
            chk("b2b_errs", {eq0[nb], eq0[nb + 1], eq0[nb + 2], eq0[nb + 3]},
                4'b0000);
        end

        // Odd parity instance: 0x00 with parity bit 1 is correct
        nb = n1;
        send_frame(8'h00, 1'b1, 1'b1);
        idle(5);
        chk("odd_count", n1 - nb, 1);
        chk("odd_perr", pe1_last, 1'b0);
        chk("odd_data", rx_data1, 8'h00);
        chk("even_perr_00p1", pe0, 1'b1);

        // Reset in the middle of data bit 4
        idle(10);
        nb = n0;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy0, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_data", rx_data0, 8'h00);
        chk("mid_rst_valid", v0, 1'b0);
        chk("mid_rst_flags", {pe0, fe0}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(120);
        chk("mid_rst_novalid", n0 - nb, 0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(5);
        chk("post_rst_count", n0 - nb, 1);
        chk("post_rst_data", rx_data0, 8'h81);
        chk("post_rst_flags", {pe0, fe0}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
